// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// data-memory wait handling with a bounded wait and a sticky timeout flag.
module hazard_unit #(
  parameter int DATA_WIDTH  = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] D_Rs1,
  input  logic [DATA_WIDTH-1:0] D_Rs2,
  input  logic                  D_UsesRs1,
  input  logic                  D_UsesRs2,
  input  logic [DATA_WIDTH-1:0] E_Rd,
  input  logic                  E_MemRead,
  input  logic                  E_RegWrite,
  input  logic                  E_BranchTaken,
  input  logic                  Mem_Busy,
  output logic                  F_Stall,
  output logic                  D_Stall,
  output logic                  E_Stall,
  output logic                  M_Stall,
  output logic                  D_Flush,
  output logic                  E_Flush,
  output logic                  Timeout_Err,
  output logic [1:0]            State,
  output logic [15:0]           Stall_Count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [15:0]       COUNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10,
    ILLEGAL    = 2'b11
  } state_t;

  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic e_stall;
    logic m_stall;
    logic d_flush;
    logic e_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_MEM    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_LOAD   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              busy_mask_q, busy_mask_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       stall_cnt_q;

  logic   load_use;
  logic   eff_busy;
  ctrl_t  run_ctrl;
  state_t run_next;
  ctrl_t  ctrl_fsm;
  ctrl_t  ctrl;

  // The load-use interlock only needs one bubble, so detection is suppressed
  // while that bubble is being inserted.
  assign load_use = E_MemRead && E_RegWrite && (E_Rd != '0)
                    && ((D_UsesRs1 && (D_Rs1 == E_Rd)) || (D_UsesRs2 && (D_Rs2 == E_Rd)))
                    && (state_q != LOAD_STALL);

  assign eff_busy = Mem_Busy && !busy_mask_q;

  // Normal-flow priority shared by RUN, LOAD_STALL and a finished MEM_WAIT.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    run_ctrl = CTRL_NONE;
    run_next = RUN;
    if (eff_busy) begin
      run_ctrl = CTRL_MEM;
      run_next = MEM_WAIT;
    end else if (E_BranchTaken) begin
      run_ctrl = CTRL_BRANCH;
    end else if (load_use) begin
      run_ctrl = CTRL_LOAD;
      run_next = LOAD_STALL;
    end
  end

  always_comb begin
    ctrl_fsm    = CTRL_NONE;
    state_d     = RUN;
    wait_d      = '0;
    busy_mask_d = busy_mask_q && Mem_Busy;
    timeout_d   = timeout_q;
    case (state_q)
      RUN, LOAD_STALL: begin
        ctrl_fsm = run_ctrl;
        state_d  = run_next;
        wait_d   = (run_next == MEM_WAIT) ? WAIT_ONE : '0;
      end
      MEM_WAIT: begin
        if (Mem_Busy) begin
          ctrl_fsm = CTRL_MEM;
          if (wait_q == WAIT_LIMIT) begin
            // Give up on the memory: release the pipeline and ignore this
            // busy level until the memory drops it at least once.
            timeout_d   = 1'b1;
            busy_mask_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
            wait_d  = wait_q + WAIT_ONE;
          end
        end else begin
          ctrl_fsm = run_ctrl;
          state_d  = run_next;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign ctrl = rst ? CTRL_NONE : ctrl_fsm;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      busy_mask_q <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      busy_mask_q <= busy_mask_d;
      timeout_q   <= timeout_d;
      if ((ctrl.f_stall || ctrl.m_stall) && (stall_cnt_q != COUNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign F_Stall     = ctrl.f_stall;
  assign D_Stall     = ctrl.d_stall;
  assign E_Stall     = ctrl.e_stall;
  assign M_Stall     = ctrl.m_stall;
  assign D_Flush     = ctrl.d_flush;
  assign E_Flush     = ctrl.e_flush;
  assign Timeout_Err = timeout_q;
  assign State       = state_q;
  assign Stall_Count = stall_cnt_q;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 5, register-address width.
REQ-002 Parameter: MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before abort. Wait counter is 8 bits at default.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 D_Rs1, D_Rs2  input  DATA_WIDTH each  decode-stage source registers.
REQ-006 D_UsesRs1, D_UsesRs2  input  1 each  decode instruction actually reads that source.
REQ-007 E_Rd  input  DATA_WIDTH  execute-stage destination register.
REQ-008 E_MemRead, E_RegWrite  input  1 each  execute-stage instruction is a load / writes the register file.
REQ-009 E_BranchTaken  input  1  execute stage resolved a taken branch or jump.
REQ-010 Mem_Busy  input  1  data memory not ready this cycle.
REQ-011 F_Stall, D_Stall, E_Stall, M_Stall  output  1 each  hold PC / IF-ID / ID-EX / EX-MEM registers.
REQ-012 D_Flush, E_Flush  output  1 each  insert bubble into IF-ID / ID-EX.
REQ-013 Timeout_Err  output  1  sticky memory-wait timeout flag.
REQ-014 State  output  2  current FSM state.
REQ-015 Stall_Count  output  16  saturating stall-cycle counter.

Function
REQ-016 The FSM states SHALL be RUN=2'b00, LOAD_STALL=2'b01 and MEM_WAIT=2'b10. Encoding 2'b11 SHALL go to RUN on the next edge.
REQ-017 Stall and flush outputs SHALL be combinational from the current state and the current inputs (Mealy), with zero-cycle latency.
REQ-018 Load-use hazard SHALL be: E_MemRead & E_RegWrite & (E_Rd != 0) & ((D_UsesRs1 & D_Rs1==E_Rd) | (D_UsesRs2 & D_Rs2==E_Rd)).
REQ-019 Priority per cycle SHALL be: effective Mem_Busy, then E_BranchTaken, then load-use hazard, then none.
REQ-020 Effective Mem_Busy SHALL be Mem_Busy & ~busy_mask, where busy_mask is an internal flag defined in REQ-027.
REQ-021 Effective Mem_Busy=1 SHALL cause:
- F_Stall, D_Stall, E_Stall and M_Stall = 1;
- both flushes = 0;
- next state MEM_WAIT.
REQ-022 Taken branch (no effective Mem_Busy) SHALL cause:
- D_Flush = E_Flush = 1;
- all stalls = 0;
- next state RUN, even if a load-use hazard is present.
REQ-023 Load-use hazard in RUN SHALL cause:
- F_Stall = D_Stall = E_Flush = 1;
- other outputs 0;
- next state LOAD_STALL.
REQ-024 In LOAD_STALL, load-use detection SHALL be masked. Other rules apply unchanged, and next state is RUN unless REQ-021 applies.
REQ-025 On entry to MEM_WAIT the wait counter SHALL be 1. It SHALL increment each MEM_WAIT cycle while Mem_Busy=1.
REQ-026 In MEM_WAIT with Mem_Busy=0, outputs and next state SHALL be exactly as in RUN for that cycle, and the wait counter SHALL clear.
REQ-027 In MEM_WAIT, when the wait counter equals MEM_TIMEOUT and Mem_Busy=1, the unit SHALL:
- keep all stalls = 1 for that cycle;
- set Timeout_Err and busy_mask;
- go to RUN on the next edge.
REQ-028 busy_mask SHALL clear on the first cycle Mem_Busy=0. Timeout_Err SHALL clear only on reset.
REQ-029 Stall_Count SHALL increment on each cycle where F_Stall | M_Stall = 1, and SHALL hold at 16'hFFFF.
REQ-030 Flush-only cycles SHALL NOT increment Stall_Count.
REQ-031 State SHALL reflect the registered FSM state.

Reset
REQ-032 With rst=1 at an edge, the following SHALL be cleared:
- State = RUN;
- wait counter = 0;
- busy_mask = 0;
- Timeout_Err = 0;
- Stall_Count = 0.
REQ-033 While rst=1, all stall and flush outputs SHALL be driven 0 regardless of inputs.
REQ-034 rst asserted mid-MEM_WAIT or mid-LOAD_STALL SHALL abort to RUN on that edge with no residual stall.

Verification
REQ-035 Load-use hazard. Stimulus: E_MemRead=1, E_RegWrite=1, E_Rd=5, D_Rs1=5, D_UsesRs1=1. Required response:
- F_Stall = D_Stall = E_Flush = 1 in that same cycle;
- State=01 next cycle with no repeat stall;
- Stall_Count=1.
REQ-036 Register x0. Stimulus: same as REQ-035 but E_Rd=0 (or D_UsesRs1=0). Required response: all outputs 0, State stays 00.
REQ-037 Branch beats hazard. Stimulus: E_BranchTaken=1 together with the REQ-035 hazard. Required response:
- D_Flush = E_Flush = 1 and F_Stall = 0;
- State stays 00;
- Stall_Count unchanged.
REQ-038 Memory wait. Stimulus: Mem_Busy=1 for 3 cycles, then 0. Required response:
- all four stalls = 1 for 3 cycles;
- State=10 during the wait, 00 after;
- Stall_Count=3.
REQ-039 Timeout. Stimulus: MEM_TIMEOUT=4, Mem_Busy held at 1. Required response:
- Timeout_Err=1 after the 4th wait cycle;
- State=00;
- stalls = 0 while Mem_Busy stays 1;
- a later Mem_Busy 0->1 stalls again.
REQ-040 Reset mid-wait. Stimulus: rst=1 during MEM_WAIT. Required response:
- next cycle State=00;
- Stall_Count=0 and Timeout_Err=0;
- outputs 0 while rst=1.
